// File: rtl/seg_display_monitor_if.sv
// Bus between a two-digit 7-segment display driver and its monitor.
// Carries the active-low digit segments plus the monitor's decoded results.
// The err_sticky signal exists only when SEG_MON_STICKY_ERR_EN is defined.
interface seg_display_monitor_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       d1;
  logic [6:0]       d0;
  logic [4:0]       value;
  logic             value_valid;
  logic             decode_err;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;
`ifdef SEG_MON_STICKY_ERR_EN
  logic             err_sticky;
`endif

  // Display driver side: drives segments, observes results
  modport master (
    output d1, d0,
    input  value, value_valid, decode_err, seq_err, locked, err_count
`ifdef SEG_MON_STICKY_ERR_EN
    , input err_sticky
`endif
  );

  // Monitor side: samples segments, produces results
  modport slave (
    input  d1, d0,
    output value, value_valid, decode_err, seq_err, locked, err_count
`ifdef SEG_MON_STICKY_ERR_EN
    , output err_sticky
`endif
  );
endinterface

// File: rtl/seg_display_monitor.sv
// Monitor for a two-digit 7-segment up-counter display.
// Filters segment transitions, decodes stable patterns and checks that the
// displayed value steps through 0..MAX_VALUE with wrap-around.
// Optional feature: define SEG_MON_STICKY_ERR_EN to add the err_sticky flag.
module seg_display_monitor #(
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_VALUE     = 15,
  parameter int ERR_W         = 8
) (
  input logic                  clock50M,
  input logic                  reset,
  seg_display_monitor_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [4:0]       MAX_V     = 5'(MAX_VALUE);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic {SEARCH, TRACK} state_t;

  state_t           state;
  logic [13:0]      samp;
  logic [13:0]      last_pat;
  logic             have_last;
  logic [CNT_W-1:0] stab_cnt;
  logic [4:0]       value_q;
  logic             value_valid_q;
  logic             decode_err_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_count_q;

  logic [4:0] tens_dec;
  logic [4:0] ones_dec;
  logic [4:0] dec_value;
  logic       legal;
  logic       accept;
  logic [4:0] next_expect;

  // Returns {valid, digit} for an active-low {g,f,e,d,c,b,a} pattern
  function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  // Decode the filtered sample and decide whether it is a new stable pattern
  always_comb begin
    tens_dec    = seg_to_digit(samp[13:7]);
    ones_dec    = seg_to_digit(samp[6:0]);
    dec_value   = (tens_dec[0] ? 5'd10 : 5'd0) + {1'b0, ones_dec[3:0]};
    legal       = tens_dec[4] && ones_dec[4] && (tens_dec[3:1] == 3'd0) &&
                  (dec_value <= MAX_V);
    accept      = (stab_cnt == STAB_LAST) && (!have_last || (samp != last_pat));
    next_expect = (value_q == MAX_V) ? 5'd0 : value_q + 5'd1;
  end

  // Sample the segment bus and count how long the sample has been unchanged
  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      samp      <= '0;
      stab_cnt  <= '0;
      last_pat  <= '0;
      have_last <= 1'b0;
    end else begin
      samp <= {bus.d1, bus.d0};
      if ({bus.d1, bus.d0} != samp)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_LAST)
        stab_cnt <= stab_cnt + CNT_W'(1);
      if (accept) begin
        last_pat  <= samp;
        have_last <= 1'b1;
      end
    end
  end

  // Lock/track FSM with registered result pulses and saturating error count
  always_ff @(posedge clock50M or posedge reset) begin
    if (reset) begin
      state         <= SEARCH;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      value_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      if (accept) begin
        if (!legal) begin
          decode_err_q <= 1'b1;
          state        <= SEARCH;
          if (err_count_q != ERR_MAX)
            err_count_q <= err_count_q + ERR_W'(1);
        end else begin
          value_q       <= dec_value;
          value_valid_q <= 1'b1;
          state         <= TRACK;
          if ((state == TRACK) && (dec_value != next_expect)) begin
            seq_err_q <= 1'b1;
            if (err_count_q != ERR_MAX)
              err_count_q <= err_count_q + ERR_W'(1);
          end
        end
      end
    end
  end

`ifdef SEG_MON_STICKY_ERR_EN
  logic err_sticky_q;

  // Remember that any error pulse has occurred since reset
  always_ff @(posedge clock50M or posedge reset) begin
    if (reset)
      err_sticky_q <= 1'b0;
    else if (decode_err_q || seq_err_q)
      err_sticky_q <= 1'b1;
  end

  assign bus.err_sticky = err_sticky_q;
`endif

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.decode_err  = decode_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.locked      = (state == TRACK);
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed self-checking bench for seg_display_monitor (STABLE_CYCLES=4,
// MAX_VALUE=15). A second instance with ERR_W=2 sees the same segments and
// is used to check error-counter saturation.
module tb_seg_display_monitor;

  logic clock50M = 1'b0;
  logic reset    = 1'b1;

  int assert_count = 0;
  int fail_count   = 0;
  int valid_seen   = 0;
  int dec_seen     = 0;
  int seq_seen     = 0;

  logic [6:0] seg_tab [0:9];

  seg_display_monitor_if #(.ERR_W(8)) bus_a ();
  seg_display_monitor_if #(.ERR_W(2)) bus_b ();

  seg_display_monitor #(.STABLE_CYCLES(4), .MAX_VALUE(15), .ERR_W(8)) dut (
    .clock50M (clock50M),
    .reset    (reset),
    .bus      (bus_a)
  );

  seg_display_monitor #(.STABLE_CYCLES(4), .MAX_VALUE(15), .ERR_W(2)) dut_sat (
    .clock50M (clock50M),
    .reset    (reset),
    .bus      (bus_b)
  );

  // 50 MHz clock
  always #10 clock50M = ~clock50M;

  // Count result pulses on the falling edge, away from the active edge
  always @(negedge clock50M) begin
    if (bus_a.value_valid) valid_seen++;
    if (bus_a.decode_err)  dec_seen++;
    if (bus_a.seq_err)     seq_seen++;
  end

  task automatic applyRaw(input logic [6:0] t, input logic [6:0] o);
    bus_a.d1 = t;
    bus_a.d0 = o;
    bus_b.d1 = t;
    bus_b.d0 = o;
  endtask

  task automatic applyStimulus(input int v);
    applyRaw(seg_tab[v / 10], seg_tab[v % 10]);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock50M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    // Reset state
    applyRaw(7'h7f, 7'h7f);
    #5;
    checkOutput("reset_value", 32'(bus_a.value), 0);
    checkOutput("reset_valid", 32'(bus_a.value_valid), 0);
    checkOutput("reset_locked", 32'(bus_a.locked), 0);
    checkOutput("reset_errcnt", 32'(bus_a.err_count), 0);
    run(2);
    reset = 1'b0;

    // Count 0..15 then wrap to 0, each held 10 cycles
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(i % 16);
      if (i == 0) begin
        run(4);
        checkOutput("latency_no_pulse", 32'(bus_a.value_valid), 0);
        checkOutput("latency_unlocked", 32'(bus_a.locked), 0);
        run(1);
      end else begin
        run(5);
      end
      checkOutput($sformatf("seq_valid_%0d", i), 32'(bus_a.value_valid), 1);
      checkOutput($sformatf("seq_value_%0d", i), 32'(bus_a.value), 32'(i % 16));
      checkOutput($sformatf("seq_locked_%0d", i), 32'(bus_a.locked), 1);
      run(5);
    end
    checkOutput("seq_pulse_count", 32'(valid_seen), 17);
    checkOutput("seq_no_dec_err", 32'(dec_seen), 0);
    checkOutput("seq_no_seq_err", 32'(seq_seen), 0);

    // Step to 5 without errors, then glitch to 7 for 3 samples
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(i);
      run(6);
    end
    applyStimulus(7);
    run(3);
    applyStimulus(5);
    run(10);
    checkOutput("glitch_pulse_count", 32'(valid_seen), 22);
    checkOutput("glitch_value", 32'(bus_a.value), 5);
    checkOutput("glitch_errcnt", 32'(bus_a.err_count), 0);

    // Skip from 5 to 7: sequence error with resync
    applyStimulus(7);
    run(5);
    checkOutput("skip_seq_err", 32'(bus_a.seq_err), 1);
    checkOutput("skip_valid", 32'(bus_a.value_valid), 1);
    checkOutput("skip_value", 32'(bus_a.value), 7);
    checkOutput("skip_errcnt", 32'(bus_a.err_count), 1);
    checkOutput("skip_locked", 32'(bus_a.locked), 1);
    run(5);
`ifdef SEG_MON_STICKY_ERR_EN
    checkOutput("sticky_set", 32'(bus_a.err_sticky), 1);
`endif

    // Blank ones digit: decode error, drop lock, value held
    applyRaw(seg_tab[0], 7'h7f);
    run(5);
    checkOutput("blank_dec_err", 32'(bus_a.decode_err), 1);
    checkOutput("blank_valid", 32'(bus_a.value_valid), 0);
    checkOutput("blank_locked", 32'(bus_a.locked), 0);
    checkOutput("blank_value", 32'(bus_a.value), 7);
    checkOutput("blank_errcnt", 32'(bus_a.err_count), 2);
    run(5);

    // Value 16 exceeds MAX_VALUE
    applyStimulus(16);
    run(5);
    checkOutput("over_dec_err", 32'(bus_a.decode_err), 1);
    checkOutput("over_seq_err", 32'(bus_a.seq_err), 0);
    checkOutput("over_errcnt", 32'(bus_a.err_count), 3);
    run(5);

    // Legal 3 from SEARCH relocks with no sequence error
    applyStimulus(3);
    run(5);
    checkOutput("relock_valid", 32'(bus_a.value_valid), 1);
    checkOutput("relock_seq_err", 32'(bus_a.seq_err), 0);
    checkOutput("relock_locked", 32'(bus_a.locked), 1);
    checkOutput("relock_value", 32'(bus_a.value), 3);
    run(5);

    // Two more decode errors: wide counter reaches 5, narrow one stops at 3
    applyRaw(seg_tab[0], 7'h7f);
    run(10);
    applyStimulus(16);
    run(10);
    checkOutput("errcnt_wide", 32'(bus_a.err_count), 5);
    checkOutput("errcnt_sat", 32'(bus_b.err_count), 3);
    checkOutput("err_pulse_count", 32'(dec_seen), 4);
    checkOutput("seq_pulse_total", 32'(seq_seen), 1);
`ifdef SEG_MON_STICKY_ERR_EN
    checkOutput("sticky_held", 32'(bus_a.err_sticky), 1);
    checkOutput("sticky_sat_inst", 32'(bus_b.err_sticky), 1);
`endif

    // Reset mid-filter: async clear, then the same pattern is accepted anew
    applyStimulus(3);
    run(2);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_value", 32'(bus_a.value), 0);
    checkOutput("midrst_locked", 32'(bus_a.locked), 0);
    checkOutput("midrst_errcnt", 32'(bus_a.err_count), 0);
    checkOutput("midrst_errcnt_sat", 32'(bus_b.err_count), 0);
`ifdef SEG_MON_STICKY_ERR_EN
    checkOutput("midrst_sticky", 32'(bus_a.err_sticky), 0);
`endif
    run(1);
    reset = 1'b0;
    run(4);
    checkOutput("postrst_no_pulse", 32'(bus_a.value_valid), 0);
    run(1);
    checkOutput("postrst_valid", 32'(bus_a.value_valid), 1);
    checkOutput("postrst_value", 32'(bus_a.value), 3);
    checkOutput("postrst_locked", 32'(bus_a.locked), 1);
    checkOutput("postrst_errcnt", 32'(bus_a.err_count), 0);
    run(3);
    checkOutput("final_pulse_count", 32'(valid_seen), 25);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
